clk_div_prog: RTL
=================

# clk_div_prog

Parametrised, runtime-programmable clock-enable generator that succeeds the fixed divide-by-3 pulse generator. It emits a one-cycle `clk_en` strobe every D cycles of `clk`, plus an optional near-50%-duty `sq_out`, from a counter whose divisor can be reloaded without producing a short or long period. It sits beside the system clock tree and feeds CPU, bus and peripheral clock enables (e.g. 4.77 MHz / 7.16 MHz CPU rates, PIT and UART timebases) from one master clock.

## Interface
- `WIDTH`, 8: divisor and counter width in bits; D range 1..2^WIDTH-1.
- `RESET_DIV`, 3: divisor in effect after reset; must satisfy 1 ≤ `RESET_DIV` ≤ 2^WIDTH-1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  1 = count; 0 = freeze counter, force `clk_en` low.
- `restart`  in  1  synchronous phase restart.
- `div_in`  in  WIDTH  new divisor value.
- `div_load`  in  1  one-cycle request to adopt `div_in`.
- `clk_en`  out  1  registered strobe, high 1 cycle per period.
- `sq_out`  out  1  registered square output (only with `CLK_DIV_PROG_SQUARE_EN`; otherwise tied 0).
- `div_cur`  out  WIDTH  divisor currently in effect.
- `load_pend`  out  1  a loaded divisor is waiting for the period boundary.

## Operation
- Reset values: `cnt`=0, `clk_en`=0, `sq_out`=0, `div_cur`=`RESET_DIV`, `div_pend`=0, `load_pend`=0.
- Effective divisor D = `div_cur`, except a value of 0 is treated as 1.
- Counting, when `run`=1: `cnt` runs 0..D-1 and wraps. On the edge where `cnt`==D-1, `cnt`←0 and `clk_en`←1; on every other edge, `clk_en`←0.
- D=1: `clk_en` is continuously high while `run`=1.
- Divisor load:
  - `div_load`=1 captures `div_in` into `div_pend` and sets `load_pend`.
  - At the next wrap edge, `div_cur`←`div_pend` and `load_pend`←0. The new D governs the very next period.
  - `div_load` on the wrap edge itself: the captured value is applied on that edge.
  - Repeated loads before the boundary: the last one wins.
- `run`=0:
  - `cnt` and `sq_out` hold; `clk_en`←0.
  - A `div_load` in this state is applied immediately.
  - When `run` returns to 1, counting resumes from the held `cnt`.
  - If the held `cnt` ≥ new D-1, the next edge is treated as the wrap edge.
- `restart`=1 (has priority over `run`):
  - `cnt`←0, `clk_en`←0, `sq_out`←0.
  - Any pending divisor is applied now. If `div_load` is also 1, `div_in` is applied directly.
  - The next period starts from the following edge.
- No FSM beyond the counter and the pending flag. `load_pend` states are IDLE / PENDING.

## Timing
- After `reset` deasserts with `run`=1: first `clk_en` is high in the cycle following the D-th rising edge. Period is then exactly D cycles.
- `clk_en`, `sq_out`, `div_cur` and `load_pend` are all registered (no combinational paths from inputs).
- Latency from `div_load` to `div_cur` update: 1 to D cycles; 1 cycle when `run`=0, when `restart` is asserted, or on a wrap edge.
- Asserting `reset` mid-period returns immediately (asynchronously) to reset values. No strobe is emitted on deassertion.

## Configuration
- `CLK_DIV_PROG_SQUARE_EN` defined:
  - `sq_out` goes high on the same edge as `clk_en`.
  - It stays high ceil(D/2) cycles and low floor(D/2) cycles.
  - For D=1 it stays high while running.
- Not defined: `sq_out` is constant 0 and the comparator logic is removed.

## Structure
- Shared constants header/package `clk_div_pkg`:
  - `CLK_DIV_MIN` = 1.
  - Divisor-decode function mapping 0 → 1.
  - Common `RESET_DIV` presets for the CPU/PIT rates.
- One natural sub-module, `clk_div_counter`: holds the counter, wrap detection and `clk_en` register. The top level adds divisor staging, restart and square logic.

## Test plan
- Reset release, `RESET_DIV`=3, `run`=1 → `clk_en` high on cycles 3, 6, 9, …; `div_cur`=3; `sq_out` high 2, low 1.
- At `cnt`=1 with D=5, `div_load` with `div_in`=2 → `load_pend`=1; the current period stays 5; the following periods are 2; `load_pend` clears at the wrap.
- `div_in`=0 loaded → behaves as D=1, with `clk_en` continuously high.
- `run` dropped at `cnt`=2 (D=6) for 10 cycles → no strobes and `cnt` holds; after `run`=1, the next strobe comes 4 cycles later.
- `restart` and `div_load` (`div_in`=4) in the same cycle mid-period → `clk_en`/`sq_out` drop immediately; `div_cur`=4 next cycle; strobes every 4 cycles.
- Async `reset` pulse between edges → outputs return to reset values without waiting for `clk`; no spurious strobe on release.

Source files
------------

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, presets and divisor decode for clk_div_prog
package clk_div_pkg;

  // Smallest divisor the counter ever runs with; a programmed 0 maps here.
  localparam int unsigned CLK_DIV_MIN = 1;

  // load_pend states: no divisor staged / divisor waiting for the wrap edge.
  localparam logic [0:0] LP_IDLE    = 1'b0;
  localparam logic [0:0] LP_PENDING = 1'b1;

  // Presets from a 14.31818 MHz master clock.
  localparam int unsigned DIV_CPU_4M77 = 3;   // 4.77 MHz CPU rate
  localparam int unsigned DIV_CPU_7M16 = 2;   // 7.16 MHz CPU rate
  localparam int unsigned DIV_PIT_1M19 = 12;  // 1.193 MHz PIT timebase

  // Divisor decode: 0 behaves as the minimum divisor.
  function automatic int unsigned div_decode(input int unsigned d);
    return (d == 0) ? CLK_DIV_MIN : d;
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// rtl/clk_div_counter.sv - period counter with wrap detection and registered clk_en strobe
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             restart,
  input  logic [WIDTH-1:0] div_eff,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             clk_en
);

  logic [WIDTH-1:0] last;

  assign last = div_eff - WIDTH'(1);

  // >= rather than == so a count held across a divisor shrink wraps on the next edge.
  assign wrap = run & ~restart & (cnt >= last);

  // Counter advance/wrap and the one-cycle strobe; restart wins over run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      clk_en <= 1'b0;
    end else if (restart) begin
      cnt    <= '0;
      clk_en <= 1'b0;
    end else if (wrap) begin
      cnt    <= '0;
      clk_en <= 1'b1;
    end else if (run) begin
      cnt    <= cnt + WIDTH'(1);
      clk_en <= 1'b0;
    end else begin
      clk_en <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock-enable generator; CLK_DIV_PROG_SQUARE_EN adds sq_out
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int unsigned RESET_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             restart,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_en,
  output logic             sq_out,
  output logic [WIDTH-1:0] div_cur,
  output logic             load_pend
);

  logic [WIDTH-1:0] div_pend;
  logic [WIDTH-1:0] div_eff;
  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic [0:0]       lp_state;

  assign div_eff   = WIDTH'(div_decode(32'(div_cur)));
  assign load_pend = (lp_state == LP_PENDING);

  clk_div_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .restart (restart),
    .div_eff (div_eff),
    .cnt     (cnt),
    .wrap    (wrap),
    .clk_en  (clk_en)
  );

  // Divisor staging: a fresh div_load overrides the staged value wherever it applies at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cur  <= WIDTH'(RESET_DIV);
      div_pend <= '0;
      lp_state <= LP_IDLE;
    end else begin
      if (div_load) begin
        div_pend <= div_in;
      end
      if (restart || wrap) begin
        if (div_load) begin
          div_cur <= div_in;
        end else if (lp_state == LP_PENDING) begin
          div_cur <= div_pend;
        end
        lp_state <= LP_IDLE;
      end else if (!run && div_load) begin
        div_cur  <= div_in;
        lp_state <= LP_IDLE;
      end else if (div_load) begin
        lp_state <= LP_PENDING;
      end
    end
  end

`ifdef CLK_DIV_PROG_SQUARE_EN
  logic [WIDTH:0] cnt_next;
  logic [WIDTH:0] half;

  assign cnt_next = {1'b0, cnt} + (WIDTH+1)'(1);
  assign half     = ({1'b0, div_eff} + (WIDTH+1)'(1)) >> 1;

  // Square output rises only with the strobe and falls once the count reaches ceil(D/2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq_out <= 1'b0;
    end else if (restart) begin
      sq_out <= 1'b0;
    end else if (wrap) begin
      sq_out <= 1'b1;
    end else if (run) begin
      sq_out <= sq_out & (cnt_next < half);
    end
  end
`else
  logic unused_cnt;

  assign unused_cnt = ^cnt;
  assign sq_out     = 1'b0;
`endif

endmodule
